// File: rtl/ddr_wr_burst_sched_if.sv
// Bundle of every signal between the burst scheduler and its neighbours: the
// video FIFO read side, the DDR command/write-data ports, and frame status.
// The master modport is the scheduler; the slave modport is the environment.
interface ddr_wr_burst_sched_if #(
  parameter int DATA_W = 256,
  parameter int WL_W   = 8,
  parameter int ADDR_W = 28
);
  logic              frame_start;
  logic              fifo_rd_en;
  logic [DATA_W-1:0] fifo_rd_data;
  logic              fifo_rd_empty;
  logic [WL_W-1:0]   fifo_rd_water_level;
  logic              cmd_valid;
  logic              cmd_ready;
  logic [ADDR_W-1:0] cmd_addr;
  logic [7:0]        cmd_len;
  logic              wdata_valid;
  logic              wdata_ready;
  logic [DATA_W-1:0] wdata;
  logic              wdata_last;
  logic              frame_done;
  logic [1:0]        frame_idx;
  logic              frame_err;

  modport master (
    input  frame_start, fifo_rd_data, fifo_rd_empty, fifo_rd_water_level,
           cmd_ready, wdata_ready,
    output fifo_rd_en, cmd_valid, cmd_addr, cmd_len, wdata_valid, wdata,
           wdata_last, frame_done, frame_idx, frame_err
  );

  modport slave (
    output frame_start, fifo_rd_data, fifo_rd_empty, fifo_rd_water_level,
           cmd_ready, wdata_ready,
    input  fifo_rd_en, cmd_valid, cmd_addr, cmd_len, wdata_valid, wdata,
           wdata_last, frame_done, frame_idx, frame_err
  );
endinterface

// File: rtl/ddr_wr_burst_sched.sv
// DDR write burst scheduler: drains the video FIFO in bursts once enough words
// are buffered, walks linear addresses through a frame buffer and rotates
// through FRAME_NUM buffers. Read data passes through a 2-entry skid buffer so
// DDR backpressure never loses a word already requested from the FIFO.
module ddr_wr_burst_sched #(
  parameter int                DATA_W       = 256,
  parameter int                WL_W         = 8,
  parameter int                ADDR_W       = 28,
  parameter int                BURST_LEN    = 16,
  parameter int                FRAME_WORDS  = 129600,
  parameter logic [ADDR_W-1:0] FRAME_BASE   = 28'h0000000,
  parameter logic [ADDR_W-1:0] FRAME_STRIDE = 28'h0800000,
  parameter int                FRAME_NUM    = 3
) (
  input logic                   clk,
  input logic                   rst,
  ddr_wr_burst_sched_if.master  bus
);
  localparam int CNT_W = $clog2(FRAME_WORDS + 1);
  localparam int LEN_W = 7;
  localparam int BYTES = DATA_W / 8;

  typedef enum logic [1:0] {IDLE, WAIT, CMD, DATA} state_t;

  state_t            state, state_nxt;
  logic [CNT_W-1:0]  word_cnt, remain, word_sum;
  logic [LEN_W-1:0]  blen_now, blen_r, beat_cnt, rd_cnt;
  logic [1:0]        frame_idx_q;
  logic              pending, inflight;
  logic [DATA_W-1:0] skid_mem [2];
  logic              skid_wp, skid_rp;
  logic [1:0]        skid_cnt;
  logic [2:0]        occ_after;
  logic              wdata_valid_int, wdata_last_int, beat_xfer, last_xfer;
  logic              frame_end, restart;
  logic              rd_en, cmd_valid_int;
  logic              clr_word, add_word, start_burst, latch_blen, set_err, set_done;
  logic              frame_done_q, frame_err_q;
  logic [ADDR_W-1:0] addr_now;

  assign remain    = CNT_W'(FRAME_WORDS) - word_cnt;
  assign blen_now  = (remain < CNT_W'(BURST_LEN)) ? LEN_W'(remain) : LEN_W'(BURST_LEN);
  assign word_sum  = word_cnt + CNT_W'(blen_r);
  assign addr_now  = FRAME_BASE + ADDR_W'(frame_idx_q) * FRAME_STRIDE
                   + ADDR_W'(word_cnt) * ADDR_W'(BYTES);

  assign wdata_valid_int = (skid_cnt != 2'd0);
  assign wdata_last_int  = wdata_valid_int && (beat_cnt == blen_r - LEN_W'(1));
  assign beat_xfer       = wdata_valid_int && bus.wdata_ready;
  assign last_xfer       = beat_xfer && wdata_last_int;
  assign frame_end       = last_xfer && (word_sum == CNT_W'(FRAME_WORDS));
  assign restart         = pending || bus.frame_start;
  // Occupancy the skid will hold next cycle, crediting a beat leaving now so
  // a read can be issued every cycle while the DDR side keeps up.
  assign occ_after = 3'(skid_cnt) + 3'(inflight) - 3'(beat_xfer);

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state decode plus the per-cycle control strobes for the datapath
  always_comb begin
    state_nxt     = state;
    rd_en         = 1'b0;
    cmd_valid_int = 1'b0;
    clr_word      = 1'b0;
    add_word      = 1'b0;
    start_burst   = 1'b0;
    latch_blen    = 1'b0;
    set_err       = 1'b0;
    set_done      = 1'b0;
    case (state)
      IDLE: begin
        if (bus.frame_start) begin
          state_nxt = WAIT;
          clr_word  = 1'b1;
        end
      end
      WAIT: begin
        if (bus.frame_start) begin
          set_err  = 1'b1;
          clr_word = 1'b1;
        end else if (bus.fifo_rd_water_level >= WL_W'(blen_now)) begin
          latch_blen = 1'b1;
          state_nxt  = CMD;
        end
      end
      CMD: begin
        cmd_valid_int = 1'b1;
        if (bus.cmd_ready) begin
          start_burst = 1'b1;
          state_nxt   = DATA;
        end else if (bus.frame_start) begin
          set_err   = 1'b1;
          clr_word  = 1'b1;
          state_nxt = WAIT;
        end
      end
      DATA: begin
        rd_en = !bus.fifo_rd_empty && (rd_cnt < blen_r) && (occ_after < 3'd2);
        if (last_xfer) begin
          add_word = 1'b1;
          if (frame_end) begin
            set_done  = 1'b1;
            state_nxt = restart ? WAIT : IDLE;
            clr_word  = restart;
          end else if (restart) begin
            set_err   = 1'b1;
            clr_word  = 1'b1;
            state_nxt = WAIT;
          end else begin
            state_nxt = WAIT;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Frame/burst counters, restart bookkeeping and status pulses
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      word_cnt     <= '0;
      blen_r       <= '0;
      beat_cnt     <= '0;
      rd_cnt       <= '0;
      pending      <= 1'b0;
      frame_idx_q  <= '0;
      frame_done_q <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      if (clr_word)      word_cnt <= '0;
      else if (add_word) word_cnt <= word_sum;
      if (latch_blen) blen_r <= blen_now;
      if (start_burst) begin
        beat_cnt <= '0;
        rd_cnt   <= '0;
        pending  <= bus.frame_start;
      end else begin
        if (beat_xfer) beat_cnt <= beat_cnt + LEN_W'(1);
        if (rd_en)     rd_cnt   <= rd_cnt + LEN_W'(1);
        if (state == DATA) begin
          if (last_xfer)            pending <= 1'b0;
          else if (bus.frame_start) pending <= 1'b1;
        end
      end
      if (set_done)
        frame_idx_q <= (frame_idx_q == 2'(FRAME_NUM - 1)) ? 2'd0 : frame_idx_q + 2'd1;
      frame_done_q <= set_done;
      frame_err_q  <= set_err;
    end
  end

  // Two-entry skid buffer catching FIFO data one cycle after each read
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      inflight    <= 1'b0;
      skid_mem[0] <= '0;
      skid_mem[1] <= '0;
      skid_wp     <= 1'b0;
      skid_rp     <= 1'b0;
      skid_cnt    <= '0;
    end else begin
      inflight <= rd_en;
      if (inflight) begin
        skid_mem[skid_wp] <= bus.fifo_rd_data;
        skid_wp           <= ~skid_wp;
      end
      if (beat_xfer) skid_rp <= ~skid_rp;
      skid_cnt <= 2'(occ_after);
    end
  end

  assign bus.fifo_rd_en  = rd_en;
  assign bus.cmd_valid   = cmd_valid_int;
  assign bus.cmd_addr    = (state == CMD) ? addr_now : '0;
  assign bus.cmd_len     = (state == CMD) ? 8'(blen_r - LEN_W'(1)) : 8'd0;
  assign bus.wdata_valid = wdata_valid_int;
  assign bus.wdata       = wdata_valid_int ? skid_mem[skid_rp] : '0;
  assign bus.wdata_last  = wdata_last_int;
  assign bus.frame_done  = frame_done_q;
  assign bus.frame_err   = frame_err_q;
  assign bus.frame_idx   = frame_idx_q;
endmodule
